// File: rtl/rasterizer_arb_pkg.sv
// Shared types and helpers for the rasterizer SDRAM arbiter.
//   arb_state_t : arbiter FSM states
//   clog2_f     : ceiling log2, usable in constant expressions
//   TAG_W/PTR_W : tag and FIFO pointer widths for the default configuration
package rasterizer_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(value)) result = i + 1;
        end
        return result;
    endfunction

    localparam int unsigned NUM_CLIENTS_DEF     = 3;
    localparam int unsigned MAX_OUTSTANDING_DEF = 8;
    localparam int unsigned TAG_W               = clog2_f(NUM_CLIENTS_DEF);
    localparam int unsigned PTR_W               = clog2_f(MAX_OUTSTANDING_DEF);

endpackage

// File: rtl/rasterizer_tag_fifo.sv
// In-order tag FIFO holding the client index of every outstanding read.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   push, din    : enqueue din (ignored while full)
//   pop          : dequeue head (ignored while empty)
//   dout         : show-ahead head entry
//   full, empty  : occupancy flags
module rasterizer_tag_fifo
    import rasterizer_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUTSTANDING_DEF,
    parameter int unsigned WIDTH = TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_BITS = clog2_f(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q, count_d;
    logic                do_push_c, do_pop_c;

    assign full      = (count_q == (PTR_BITS+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign dout      = mem_q[rd_ptr_q];
    assign do_push_c = push & ~full;
    assign do_pop_c  = pop & ~empty;

    // Pointers wrap by natural overflow (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + (PTR_BITS+1)'(1);
            2'b01:   count_d = count_q - (PTR_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (do_push_c) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/rasterizer_mem_arbiter.sv
// N-client Avalon-MM arbiter merging rasterizer stage masters onto one SDRAM port.
// Reads are tagged in an in-order FIFO so each readdatavalid returns to its issuer.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (client 0 highest);
// otherwise clients are served round-robin.
// Ports:
//   clock, reset               : clock, synchronous active-high reset
//   client_* (packed per i)    : client Avalon-MM masters (address/read/write/be/wdata in,
//                                waitrequest/readdatavalid out, readdata broadcast)
//   master_*                   : single Avalon-MM master toward the SDRAM controller
//   orphan_error               : sticky, read data arrived with no outstanding tag
module rasterizer_mem_arbiter
    import rasterizer_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS     = NUM_CLIENTS_DEF,
    parameter int unsigned ADDR_W          = 26,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]   client_address,
    input  logic [NUM_CLIENTS-1:0]          client_read,
    input  logic [NUM_CLIENTS-1:0]          client_write,
    input  logic [NUM_CLIENTS*DATA_W/8-1:0] client_byteenable,
    input  logic [NUM_CLIENTS*DATA_W-1:0]   client_writedata,
    output logic [NUM_CLIENTS-1:0]          client_waitrequest,
    output logic [DATA_W-1:0]               client_readdata,
    output logic [NUM_CLIENTS-1:0]          client_readdatavalid,
    output logic [ADDR_W-1:0]               master_address,
    output logic                            master_read,
    output logic                            master_write,
    output logic [DATA_W/8-1:0]             master_byteenable,
    output logic [DATA_W-1:0]               master_writedata,
    input  logic                            master_waitrequest,
    input  logic [DATA_W-1:0]               master_readdata,
    input  logic                            master_readdatavalid,
    output logic                            orphan_error
);

    localparam int unsigned TAG_BITS = clog2_f(NUM_CLIENTS);
    localparam int unsigned BE_W     = DATA_W / 8;

    arb_state_t          state_q, state_d;
    logic [TAG_BITS-1:0] grant_q, grant_d;
    logic                orphan_q, orphan_d;

    logic [NUM_CLIENTS-1:0] req_c;
    logic [TAG_BITS-1:0]    start_c, win_c, idx_c, tag_dout_c;
    logic                   fifo_push_c, fifo_pop_c, fifo_full_c, fifo_empty_c;
    logic                   sel_rd_c, sel_wr_c, is_rd_c, is_wr_c, accept_c;
    logic [ADDR_W-1:0]      sel_addr_c;
    logic [BE_W-1:0]        sel_be_c;
    logic [DATA_W-1:0]      sel_wdata_c;

    assign req_c = client_read | client_write;

`ifdef ARB_FIXED_PRIO_EN
    assign start_c = '0;
`else
    // Holds the first client to consider, i.e. last_grant + 1.
    logic [TAG_BITS-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept_c) begin
            rr_ptr_d = (grant_q == TAG_BITS'(NUM_CLIENTS - 1)) ? '0 : grant_q + TAG_BITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign start_c = rr_ptr_q;
`endif

    // Scan from start_c backwards so the nearest requester after start_c wins last.
    always_comb begin
        win_c = start_c;
        idx_c = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx_c = TAG_BITS'((int'(start_c) + k) % int'(NUM_CLIENTS));
            if (req_c[idx_c]) win_c = idx_c;
        end
    end

    // Granted client's request; write beats read when both are asserted.
    always_comb begin
        sel_rd_c    = 1'b0;
        sel_wr_c    = 1'b0;
        sel_addr_c  = '0;
        sel_be_c    = '0;
        sel_wdata_c = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_q == TAG_BITS'(i)) begin
                sel_rd_c    = client_read[i];
                sel_wr_c    = client_write[i];
                sel_addr_c  = client_address[i*ADDR_W +: ADDR_W];
                sel_be_c    = client_byteenable[i*BE_W +: BE_W];
                sel_wdata_c = client_writedata[i*DATA_W +: DATA_W];
            end
        end
        is_wr_c = sel_wr_c;
        is_rd_c = sel_rd_c & ~sel_wr_c;
    end

    // Next-state and master/handshake outputs.
    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        fifo_push_c        = 1'b0;
        accept_c           = 1'b0;
        master_address     = '0;
        master_read        = 1'b0;
        master_write       = 1'b0;
        master_byteenable  = '0;
        master_writedata   = '0;
        client_waitrequest = '1;
        case (state_q)
            IDLE: begin
                if (|req_c) begin
                    grant_d = win_c;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                master_address    = sel_addr_c;
                master_byteenable = sel_be_c;
                master_writedata  = sel_wdata_c;
                master_write      = is_wr_c;
                master_read       = is_rd_c & ~fifo_full_c;
                for (int i = 0; i < NUM_CLIENTS; i++) begin
                    if (grant_q == TAG_BITS'(i)) begin
                        client_waitrequest[i] = master_waitrequest | (is_rd_c & fifo_full_c);
                    end
                end
                accept_c = (is_rd_c | is_wr_c) & ~master_waitrequest & ~(is_rd_c & fifo_full_c);
                if (accept_c) begin
                    fifo_push_c = is_rd_c;
                    state_d     = IDLE;
                end else if (!(is_rd_c | is_wr_c)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read return routing: head tag selects the client, zero added latency.
    assign fifo_pop_c      = master_readdatavalid & ~fifo_empty_c;
    assign client_readdata = master_readdata;
    assign orphan_d        = orphan_q | (master_readdatavalid & fifo_empty_c);
    assign orphan_error    = orphan_q;

    always_comb begin
        client_readdatavalid = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (fifo_pop_c && (tag_dout_c == TAG_BITS'(i))) client_readdatavalid[i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            orphan_q <= orphan_d;
        end
    end

    rasterizer_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_BITS)
    ) u_tag_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push_c),
        .pop   (fifo_pop_c),
        .din   (grant_q),
        .dout  (tag_dout_c),
        .full  (fifo_full_c),
        .empty (fifo_empty_c)
    );

endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Scoreboard bench for rasterizer_mem_arbiter: tests queue expected accepts and
// read returns; a negedge monitor pops and compares whenever the DUT presents one.
module tb_rasterizer_mem_arbiter;

    localparam int unsigned NC = 3;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 8;
    localparam int unsigned BW = DW / 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [NC*AW-1:0] client_address;
    logic [NC-1:0]    client_read;
    logic [NC-1:0]    client_write;
    logic [NC*BW-1:0] client_byteenable;
    logic [NC*DW-1:0] client_writedata;
    logic [NC-1:0]    client_waitrequest;
    logic [DW-1:0]    client_readdata;
    logic [NC-1:0]    client_readdatavalid;
    logic [AW-1:0]    master_address;
    logic             master_read;
    logic             master_write;
    logic [BW-1:0]    master_byteenable;
    logic [DW-1:0]    master_writedata;
    logic             master_waitrequest;
    logic [DW-1:0]    master_readdata;
    logic             master_readdatavalid;
    logic             orphan_error;

    typedef struct {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } req_t;

    typedef struct {
        int            cl;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } acc_t;

    typedef struct {
        logic [NC-1:0] vld;
        logic [DW-1:0] data;
    } ret_t;

    req_t cq [NC][$];
    acc_t acc_q[$];
    ret_t ret_q[$];
    int   acc_cyc[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    rasterizer_mem_arbiter #(
        .NUM_CLIENTS     (NC),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .client_address       (client_address),
        .client_read          (client_read),
        .client_write         (client_write),
        .client_byteenable    (client_byteenable),
        .client_writedata     (client_writedata),
        .client_waitrequest   (client_waitrequest),
        .client_readdata      (client_readdata),
        .client_readdatavalid (client_readdatavalid),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_byteenable    (master_byteenable),
        .master_writedata     (master_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .orphan_error         (orphan_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Queue a request on a client and its expected accept on the scoreboard.
    task automatic issue(input int cl, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        acc_t e;
        r.rd = rd; r.addr = a; r.data = d; r.be = BW'(cl + 1);
        cq[cl].push_back(r);
        e.cl = cl; e.rd = rd; e.addr = a; e.data = d; e.be = r.be;
        acc_q.push_back(e);
    endtask

    task automatic expect_ret(input logic [NC-1:0] v, input logic [DW-1:0] d);
        ret_t e;
        e.vld = v; e.data = d;
        ret_q.push_back(e);
    endtask

    task automatic wait_acc(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (acc_q.size() > target && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 64'(acc_q.size()), 64'(target));
    endtask

    task automatic wait_ret(input int budget, input string nm);
        int n;
        n = 0;
        while (ret_q.size() > 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 64'(ret_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_master_read"},  master_read, 0);
        chk({tag, "_master_write"}, master_write, 0);
        chk({tag, "_master_addr"},  master_address, 0);
        chk({tag, "_master_be"},    master_byteenable, 0);
        chk({tag, "_master_wdata"}, master_writedata, 0);
        chk({tag, "_client_wait"},  client_waitrequest, 3'b111);
        chk({tag, "_client_rdv"},   client_readdatavalid, 0);
        chk({tag, "_orphan"},       orphan_error, 0);
    endtask

    // Avalon client masters: hold each request until a cycle with waitrequest low.
    always begin : drv
        logic [NC-1:0] acc;
        req_t          r;
        @(negedge clock);
        for (int i = 0; i < NC; i++)
            acc[i] = (client_read[i] | client_write[i]) & ~client_waitrequest[i];
        @(posedge clock);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (acc[i] || !(client_read[i] | client_write[i])) begin
                if (cq[i].size() > 0) begin
                    r = cq[i].pop_front();
                    client_read[i]  = r.rd;
                    client_write[i] = ~r.rd;
                    client_address[i*AW +: AW]    = r.addr;
                    client_writedata[i*DW +: DW]  = r.data;
                    client_byteenable[i*BW +: BW] = r.be;
                end else begin
                    client_read[i]  = 1'b0;
                    client_write[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every accepted transfer and every routed read return.
    always @(negedge clock) begin : mon
        int   g;
        acc_t e;
        ret_t rr;
        if (!reset) begin
            if ((master_read | master_write) && !master_waitrequest) begin
                acc_cyc.push_back(cyc);
                g = -1;
                for (int i = 0; i < NC; i++) if (!client_waitrequest[i]) g = i;
                if (acc_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL acc_unexpected: addr 0x%0h accepted with none expected", master_address);
                end else begin
                    e = acc_q.pop_front();
                    chk("acc_client",  64'(g), 64'(e.cl));
                    chk("acc_is_read", master_read, e.rd);
                    chk("acc_addr",    master_address, e.addr);
                    chk("acc_be",      master_byteenable, e.be);
                    if (!e.rd) chk("acc_wdata", master_writedata, e.data);
                end
            end
            if (client_readdatavalid != '0) begin
                if (ret_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL ret_unexpected: rdv 0x%0h with none expected", client_readdatavalid);
                end else begin
                    rr = ret_q.pop_front();
                    chk("ret_onehot", client_readdatavalid, rr.vld);
                    chk("ret_data",   client_readdata, rr.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        client_address = '0; client_read = '0; client_write = '0;
        client_byteenable = '0; client_writedata = '0;
        master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("reset");

        // All three clients writing back-to-back.
        acc_cyc.delete();
`ifdef ARB_FIXED_PRIO_EN
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < 2; k++)
                issue(c, 1'b0, AW'(32'h1000 + c*16 + k), DW'(32'hD000_0000 + c*256 + k));
`else
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NC; c++)
                issue(c, 1'b0, AW'(32'h1000 + c*16 + k), DW'(32'hD000_0000 + c*256 + k));
`endif
        wait_acc(0, 60, "t1_drain");
        for (int k = 1; k < 6; k++)
            chk("t1_accept_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd2);

        // Two reads from different clients, returned in order.
        issue(1, 1'b1, AW'(32'h100), '0);
        issue(2, 1'b1, AW'(32'h200), '0);
        wait_acc(0, 40, "t2_accepts");
        expect_ret(3'b010, 32'h0000_AAAA);
        expect_ret(3'b100, 32'h0000_BBBB);
        @(posedge clock); #1 master_readdatavalid = 1'b1; master_readdata = 32'h0000_AAAA;
        @(posedge clock); #1 master_readdatavalid = 1'b0;
        @(posedge clock); #1 master_readdatavalid = 1'b1; master_readdata = 32'h0000_BBBB;
        @(posedge clock); #1 master_readdatavalid = 1'b0;
        wait_ret(10, "t2_returns");

        // SDRAM stall for 5 cycles during a client 0 write.
        @(posedge clock);
        #2;
        master_waitrequest = 1'b1;
        issue(0, 1'b0, AW'(32'h3000), DW'(32'h3333_0000));
        issue(1, 1'b0, AW'(32'h3010), DW'(32'h3333_0001));
        issue(2, 1'b0, AW'(32'h3020), DW'(32'h3333_0002));
        @(posedge clock);
        #2;
        @(negedge clock);
        chk("t3_idle_no_write", master_write, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t3_stall_addr",  master_address, 26'h3000);
            chk("t3_stall_write", master_write, 1);
            chk("t3_stall_wait",  client_waitrequest, 3'b111);
        end
        @(posedge clock); #1 master_waitrequest = 1'b0;
        @(negedge clock);
        chk("t3_accept_wait", client_waitrequest, 3'b110);
        chk("t3_accept_addr", master_address, 26'h3000);
        wait_acc(0, 40, "t3_drain");

        // Fill the tag FIFO, then a 9th read must stall until one return.
        for (int k = 0; k < 9; k++) issue(0, 1'b1, AW'(32'h400 + k), '0);
        wait_acc(1, 80, "t4_eight_reads");
        repeat (3) @(negedge clock);
        chk("t4_full_read",  master_read, 0);
        chk("t4_full_wait",  client_waitrequest, 3'b111);
        chk("t4_full_addr",  master_address, 26'h408);
        expect_ret(3'b001, 32'h0000_5555);
        @(posedge clock); #1 master_readdatavalid = 1'b1; master_readdata = 32'h0000_5555;
        @(negedge clock);
        chk("t4_pop_cycle_read", master_read, 0);
        @(posedge clock); #1 master_readdatavalid = 1'b0;
        @(negedge clock);
        chk("t4_ninth_read", master_read, 1);
        chk("t4_ninth_wait", client_waitrequest, 3'b110);
        wait_acc(0, 5, "t4_ninth_accept");
        for (int k = 0; k < 8; k++) expect_ret(3'b001, DW'(32'h6000 + k));
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1 master_readdatavalid = 1'b1; master_readdata = DW'(32'h6000 + k);
        end
        @(posedge clock); #1 master_readdatavalid = 1'b0;
        wait_ret(10, "t4_drain");

        // Reset with a read outstanding; the late return becomes an orphan.
        issue(1, 1'b1, AW'(32'h700), '0);
        wait_acc(0, 20, "t5_accept");
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("t5_reset");
        @(posedge clock); #1 master_readdatavalid = 1'b1; master_readdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("t5_orphan_rdv",   client_readdatavalid, 0);
        chk("t5_orphan_early", orphan_error, 0);
        @(posedge clock); #1 master_readdatavalid = 1'b0;
        @(negedge clock);
        chk("t5_orphan_set", orphan_error, 1);
        @(negedge clock);
        chk("t5_orphan_sticky", orphan_error, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("t5_orphan_cleared", orphan_error, 0);

        // Clients 0 and 2 requesting continuously.
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++) issue(0, 1'b0, AW'(32'h5000 + k), DW'(32'hA0 + k));
        for (int k = 0; k < 2; k++) issue(2, 1'b0, AW'(32'h5200 + k), DW'(32'hC0 + k));
`else
        issue(0, 1'b0, AW'(32'h5000), DW'(32'hA0));
        issue(2, 1'b0, AW'(32'h5200), DW'(32'hC0));
        issue(0, 1'b0, AW'(32'h5001), DW'(32'hA1));
        issue(2, 1'b0, AW'(32'h5201), DW'(32'hC1));
        issue(0, 1'b0, AW'(32'h5002), DW'(32'hA2));
`endif
        wait_acc(0, 60, "t6_drain");

        repeat (2) @(negedge clock);
        chk("final_ret_empty", 64'(ret_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
